doodle_physics: RTL

Per-frame motion engine for the doodle sprite. Consumes the registered `delta_x` and `game_state` from the game controller, integrates horizontal motion with screen wrap and vertical motion under gravity, bounces on the ground or on platforms, and scrolls the world. Its `doodle_y` feeds back to the controller for game-over detection. Its `scroll_dy` feeds the platform generator.

---
 rtl/doodle_pkg.sv | 7 +
 rtl/doodle_physics_wrap_add.sv | 18 +
 rtl/doodle_physics.sv | 72 +++++++
 3 files changed

// File: rtl/doodle_pkg.sv
// doodle_pkg: shared game state encoding and screen geometry for the doodle game blocks
package doodle_pkg;
  typedef enum logic [1:0] {MENU = 2'd0, PLAY = 2'd1, OVER = 2'd2} game_state_t;
  localparam int SCREEN_WIDTH = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int COORD_W = 10;
endpackage

// File: rtl/doodle_physics_wrap_add.sv
// wrap_add: unsigned coordinate plus signed step, wrapped modulo MOD (|d| < MOD)
module wrap_add #(
  parameter int W   = 10,
  parameter int DW  = 9,
  parameter int MOD = 640
) (
  input  logic [W-1:0]         a,
  input  logic signed [DW-1:0] d,
  output logic [W-1:0]         sum
);
  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] M = SW'(MOD);
  logic signed [SW-1:0] s;
  always_comb begin
    s = $signed({2'b00, a}) + $signed({{(SW-DW){d[DW-1]}}, d});
    sum = s < 12'sd0 ? W'(s + M) : s >= M ? W'(s - M) : W'(s);
  end
endmodule

// File: rtl/doodle_physics.sv
// doodle_physics: per-frame sprite motion with horizontal wrap, gravity, bounces and world scroll
module doodle_physics
  import doodle_pkg::*;
#(
  parameter int FPS           = 60,
  parameter int CLK           = 25_000_000,
  parameter int EARTH         = 440,
  parameter int DOODLE_HEIGHT = 40,
  parameter int SCREEN_WIDTH  = 640,
  parameter int START_X       = 300,
  parameter int SCROLL_LINE   = 160,
  parameter int JUMP_VELOCITY = 12,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(CLK/FPS):0]      fps_counter,
  input  logic signed [8:0]             delta_x,
  input  logic [1:0]                    game_state,
  input  logic                          platform_hit,
  output logic [COORD_W-1:0]            doodle_x,
  output logic [COORD_W-1:0]            doodle_y,
  output logic signed [7:0]             velocity_y,
  output logic                          facing_left,
  output logic [COORD_W-1:0]            scroll_dy,
  output logic                          frame_done
);
  localparam logic signed [11:0] E = 12'(EARTH), H = 12'(DOODLE_HEIGHT), SL = 12'(SCROLL_LINE);
  localparam logic signed [11:0] J = 12'(JUMP_VELOCITY), G = 12'(GRAVITY), MF = 12'(MAX_FALL);
  logic tick, in_menu, in_play, bounce;
  logic signed [11:0] y_s, vy_s, yn, vg, y_nx, vy_nx, sc_nx;
  logic [COORD_W-1:0] x_nx;
  wrap_add #(.W(COORD_W), .DW(9), .MOD(SCREEN_WIDTH)) u_wrap (
    .a(doodle_x), .d(delta_x), .sum(x_nx)
  );
  // Menu bounces off the ground; play only bounces off platforms while falling.
  always_comb begin
    tick = &fps_counter;
    in_menu = game_state == MENU;
    in_play = game_state == PLAY;
    y_s = $signed({2'b00, doodle_y});
    vy_s = {{4{velocity_y[7]}}, velocity_y};
    yn = y_s + vy_s;
    vg = vy_s >= MF - G ? MF : vy_s + G;
    bounce = in_menu ? (yn + H >= E && vy_s >= 12'sd0) : (platform_hit && vy_s > 12'sd0);
    vy_nx = bounce ? -J : vg;
    y_nx = in_menu ? (bounce ? E - H : yn < 12'sd0 ? 12'sd0 : yn)
                   : (yn < SL ? SL : yn > E ? E : yn);
    sc_nx = in_play && yn < SL ? SL - yn : 12'sd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      doodle_x <= COORD_W'(START_X);
      doodle_y <= COORD_W'(EARTH - DOODLE_HEIGHT);
      velocity_y <= '0;
      facing_left <= 1'b0;
      scroll_dy <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick;
      scroll_dy <= '0;
      if (tick && (in_menu || in_play)) begin
        doodle_x <= x_nx;
        doodle_y <= y_nx[COORD_W-1:0];
        velocity_y <= vy_nx[7:0];
        scroll_dy <= sc_nx[COORD_W-1:0];
        if (|delta_x) facing_left <= delta_x[8];
      end
    end
  end
endmodule
